// File: rtl/mult_pkg.sv
// Shared constants and state encoding for the signed add-shift multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mult_pkg;

    localparam int WIDTH  = 8;
    localparam int N_ITER = 8;
    localparam int KW     = $clog2(N_ITER);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/nine_bit_adder.sv
// Sign-extended 8+1 bit adder: s = sext(x) + sext(y) + cin.
// Latency: combinational.
// Backpressure: none.
module nine_bit_adder
    import mult_pkg::*;
(
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic [WIDTH:0]   s
);

    // Bit 8 of the result is the true sign, so A+S or A-S never overflows.
    assign s = {x[WIDTH-1], x} + {y[WIDTH-1], y} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencer for 8x8 signed add-shift multiply; product lands in {A,B}, sign in X.
// Latency: 16 busy cycles after Run is sampled in IDLE, then HOLD with done.
// Backpressure: Run is a level; HOLD is kept until Run drops, one multiply per assertion.
module mult_seq_ctrl #(
    parameter int WIDTH = 8  // adder datapath is fixed at 8+1 bits; only 8 is legal
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Run,
    input  logic             ClearA_LoadB,
    input  logic [WIDTH-1:0] Sw,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             Xval,
    output logic             busy,
    output logic             done
);
    import mult_pkg::*;

    state_t          state;
    state_t          state_nxt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] s_reg;
    logic             x_reg;
    logic [KW-1:0]    k;
    logic             last;
    logic [WIDTH-1:0] y_op;
    logic [WIDTH:0]   sum;

    // The final iteration weights the multiplier sign bit negatively, so it subtracts.
    assign last = (k == KW'(N_ITER - 1));
    assign y_op = last ? ~s_reg : s_reg;

    nine_bit_adder u_adder (
        .x   (a_reg),
        .y   (y_op),
        .cin (last),
        .s   (sum)
    );

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a load request in IDLE defers any start by a cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!ClearA_LoadB && Run) state_nxt = ADD;
            ADD:     state_nxt = SHIFT;
            SHIFT:   state_nxt = last ? HOLD : ADD;
            HOLD:    if (!Run) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: load/clear in IDLE, conditional add in ADD, arithmetic shift in SHIFT.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            a_reg <= '0;
            b_reg <= '0;
            s_reg <= '0;
            x_reg <= 1'b0;
            k     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ClearA_LoadB) begin
                        a_reg <= '0;
                        x_reg <= 1'b0;
                        b_reg <= Sw;
                    end else if (Run) begin
                        s_reg <= Sw;
                        a_reg <= '0;
                        x_reg <= 1'b0;
                        k     <= '0;
                    end
                end
                ADD: begin
                    if (b_reg[0]) begin
                        x_reg <= sum[WIDTH];
                        a_reg <= sum[WIDTH-1:0];
                    end
                end
                SHIFT: begin
                    a_reg <= {x_reg, a_reg[WIDTH-1:1]};
                    b_reg <= {a_reg[0], b_reg[WIDTH-1:1]};
                    if (!last) k <= k + KW'(1);
                end
                default: ;
            endcase
        end
    end

    // Outputs come straight from registers; nothing combinational from inputs.
    assign Aval = a_reg;
    assign Bval = b_reg;
    assign Xval = x_reg;
    assign busy = (state == ADD) || (state == SHIFT);
    assign done = (state == HOLD);

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Randomised and directed bench for mult_seq_ctrl against a plain signed-product model.
// Latency: checks 16 busy cycles per multiply and done immediately after.
// Backpressure: exercises Run held through HOLD and load/start collisions.
module tb_mult_seq_ctrl;

    logic       Clk;
    logic       Reset_n;
    logic       Run;
    logic       ClearA_LoadB;
    logic [7:0] Sw;
    logic [7:0] Aval;
    logic [7:0] Bval;
    logic       Xval;
    logic       busy;
    logic       done;

    int n_vec;
    int n_err;
    logic [7:0] model_b;  // multiplier the DUT should currently hold in B

    mult_seq_ctrl #(.WIDTH(8)) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .Run          (Run),
        .ClearA_LoadB (ClearA_LoadB),
        .Sw           (Sw),
        .Aval         (Aval),
        .Bval         (Bval),
        .Xval         (Xval),
        .busy         (busy),
        .done         (done)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Reference: 16-bit two's-complement product of two signed bytes.
    function automatic logic [15:0] ref_mul(input logic [7:0] s, input logic [7:0] b);
        int si;
        int bi;
        int p;
        si = $signed(s);
        bi = $signed(b);
        p  = si * bi;
        return p[15:0];
    endfunction

    // Drive inputs and sample outputs on the falling edge.
    task automatic load_b(input logic [7:0] b);
        ClearA_LoadB = 1'b1;
        Sw           = b;
        @(negedge Clk);
        ClearA_LoadB = 1'b0;
        model_b      = b;
    endtask

    // Start a multiply and count busy cycles (bounded); returns in HOLD with Run still high.
    task automatic start_and_wait(input logic [7:0] s, input bit toggle_sw, output int cnt);
        Run = 1'b1;
        Sw  = s;
        @(negedge Clk);
        cnt = 0;
        while (busy && cnt < 40) begin
            cnt++;
            if (toggle_sw) Sw = 8'($urandom);
            @(negedge Clk);
        end
    endtask

    task automatic drop_run();
        Run = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_reset();
        int cnt;
        Reset_n = 1'b0; Run = 1'b0; ClearA_LoadB = 1'b0; Sw = 8'h00;
        model_b = 8'h00;
        repeat (2) @(negedge Clk);
        n_vec++;
        if ({Aval, Bval, Xval, busy, done} !== 19'h0) begin
            n_err++;
            $display("FAIL reset_init: got A=%h B=%h X=%b busy=%b done=%b, want all zero",
                     Aval, Bval, Xval, busy, done);
        end
        Reset_n = 1'b1;
        @(negedge Clk);
        load_b(8'h55);
        Run = 1'b1; Sw = 8'h33;
        @(negedge Clk);                 // ADD, k=0
        repeat (7) @(negedge Clk);      // SHIFT, k=3
        cnt = busy ? 1 : 0;
        #1 Reset_n = 1'b0;
        #1;
        n_vec++;
        if (cnt != 1 || {Aval, Bval, Xval, busy, done} !== 19'h0) begin
            n_err++;
            $display("FAIL reset_mid_shift: busy_before=%0d got A=%h B=%h X=%b busy=%b done=%b, want busy_before=1 and all zero",
                     cnt, Aval, Bval, Xval, busy, done);
        end
        Run = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        model_b = 8'h00;
        @(negedge Clk);
    endtask

    task automatic test_directed();
        logic [7:0] bs [4] = '{8'h03, 8'hFF, 8'h80, 8'h80};
        logic [7:0] ss [4] = '{8'h07, 8'hFF, 8'h80, 8'h7F};
        logic [16:0] want [4] = '{{1'b0, 16'h0015}, {1'b0, 16'h0001},
                                  {1'b0, 16'h4000}, {1'b1, 16'hC080}};
        int cnt;
        for (int i = 0; i < 4; i++) begin
            load_b(bs[i]);
            start_and_wait(ss[i], 1'b0, cnt);
            n_vec++;
            if (cnt != 16 || done !== 1'b1 || {Xval, Aval, Bval} !== want[i]) begin
                n_err++;
                $display("FAIL directed_%0d: busy=%0d done=%b X,A,B=%b,%h,%h want busy=16 done=1 X,A,B=%b,%h,%h",
                         i, cnt, done, Xval, Aval, Bval, want[i][16], want[i][15:8], want[i][7:0]);
            end
            drop_run();
            model_b = want[i][7:0];
        end
    endtask

    task automatic test_random();
        logic [7:0] s;
        logic [15:0] p;
        int cnt;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) != 0) load_b(8'($urandom));
            s = 8'($urandom);
            p = ref_mul(s, model_b);
            start_and_wait(s, i[0], cnt);
            n_vec++;
            if (cnt != 16 || done !== 1'b1 || {Aval, Bval} !== p || Xval !== p[15]) begin
                n_err++;
                $display("FAIL random_%0d: s=%h b=%h busy=%0d done=%b X,A,B=%b,%h,%h want busy=16 done=1 X,A,B=%b,%h,%h",
                         i, s, model_b, cnt, done, Xval, Aval, Bval, p[15], p[15:8], p[7:0]);
            end
            drop_run();
            model_b = p[7:0];
        end
    endtask

    task automatic test_run_held();
        logic [15:0] p;
        int cnt;
        load_b(8'hF3);
        p = ref_mul(8'h2D, 8'hF3);
        start_and_wait(8'h2D, 1'b0, cnt);
        for (int i = 0; i < 6; i++) begin
            Sw = 8'($urandom);
            @(negedge Clk);
            n_vec++;
            if (busy !== 1'b0 || done !== 1'b1 || {Aval, Bval} !== p) begin
                n_err++;
                $display("FAIL run_held_%0d: busy=%b done=%b A,B=%h,%h want busy=0 done=1 A,B=%h,%h",
                         i, busy, done, Aval, Bval, p[15:8], p[7:0]);
            end
        end
        drop_run();
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || {Aval, Bval} !== p) begin
            n_err++;
            $display("FAIL run_release: busy=%b done=%b A,B=%h,%h want busy=0 done=0 A,B=%h,%h",
                     busy, done, Aval, Bval, p[15:8], p[7:0]);
        end
        model_b = p[7:0];
    endtask

    task automatic test_back_to_back();
        logic [15:0] p;
        int cnt;
        // Load and start requested together: load wins, start follows a cycle later.
        Run = 1'b1; ClearA_LoadB = 1'b1; Sw = 8'h9C;
        @(negedge Clk);
        n_vec++;
        if (busy !== 1'b0 || Bval !== 8'h9C) begin
            n_err++;
            $display("FAIL clr_run_same_cycle: busy=%b B=%h want busy=0 B=9c", busy, Bval);
        end
        ClearA_LoadB = 1'b0;
        model_b = 8'h9C;
        p = ref_mul(8'hB7, model_b);
        start_and_wait(8'hB7, 1'b1, cnt);
        n_vec++;
        if (cnt != 16 || done !== 1'b1 || {Aval, Bval} !== p || Xval !== p[15]) begin
            n_err++;
            $display("FAIL deferred_start: busy=%0d done=%b X,A,B=%b,%h,%h want busy=16 done=1 X,A,B=%b,%h,%h",
                     cnt, done, Xval, Aval, Bval, p[15], p[15:8], p[7:0]);
        end
        drop_run();
        model_b = p[7:0];
        // Run dropped mid-multiply: operation completes, HOLD left on the next cycle.
        p = ref_mul(8'h45, model_b);
        Run = 1'b1; Sw = 8'h45;
        @(negedge Clk);
        Run = 1'b0;
        ClearA_LoadB = 1'b1;   // must be ignored while busy
        cnt = 0;
        while (busy && cnt < 40) begin
            cnt++;
            @(negedge Clk);
        end
        n_vec++;
        if (cnt != 16 || done !== 1'b1 || {Aval, Bval} !== p) begin
            n_err++;
            $display("FAIL run_drop_busy: busy=%0d done=%b A,B=%h,%h want busy=16 done=1 A,B=%h,%h",
                     cnt, done, Aval, Bval, p[15:8], p[7:0]);
        end
        ClearA_LoadB = 1'b0;
        @(negedge Clk);
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL hold_exit: done=%b busy=%b want done=0 busy=0", done, busy);
        end
        model_b = p[7:0];
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_directed();
        test_random();
        test_run_held();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
